dma_channel_arbiter: RTL and testbench
======================================

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 Port CLK, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-002 Port RESET, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-003 Port DREQ, input, 4 bits, SHALL carry the active-high channel requests; bit n belongs to channel n.
REQ-004 Port maskReg, input, 4 bits, SHALL block the request of channel n while bit n is 1.
REQ-005 Port priorityType, input, 1 bit, SHALL select fixed priority when 0 and rotating priority when 1.
REQ-006 Port ctrlDisable, input, 1 bit, SHALL block any new arbitration while 1.
REQ-007 Port HLDA, input, 1 bit, SHALL carry the CPU hold acknowledge.
REQ-008 Port EOP_N, input, 1 bit, SHALL be the active-low external end of process.
REQ-009 Port transferDone, input, 1 bit, SHALL be a one-cycle pulse from timing control that ends the current single transfer.
REQ-010 Port HRQ, output, 1 bit, SHALL carry the hold request to the CPU.
REQ-011 Port DACK, output, 4 bits, SHALL carry the one-hot, active-high acknowledge of the granted channel.
REQ-012 Port activeChannel, output, 2 bits, SHALL hold the index of the latched winner.
REQ-013 Port grantValid, output, 1 bit, SHALL be 1 exactly while DACK is non-zero.
REQ-014 Port priorityOrder, output, 8 bits, SHALL hold four 2-bit channel IDs; bits [1:0] are the highest priority and bits [7:6] the lowest.

Function
REQ-015 The effective request SHALL be eff = DREQ & ~maskReg.
REQ-016 The FSM SHALL be one-hot with four states: IDLE, REQ, GRANT and RELEASE.
REQ-017 In IDLE, when eff != 0 and ctrlDisable == 0, the block SHALL:
- latch the highest-priority set bit of eff, according to priorityOrder, into activeChannel;
- go to REQ.
HRQ SHALL be 1 from the next cycle.
REQ-018 In IDLE with eff == 0 or ctrlDisable == 1, the block SHALL stay in IDLE with HRQ=0 and DACK=0.
REQ-019 In REQ, HRQ SHALL be 1 and DACK SHALL be 0.
- If HLDA == 1, the block SHALL go to GRANT.
- If HLDA == 0 and eff[activeChannel] == 0, it SHALL return to IDLE, and HRQ SHALL be 0 the next cycle.
REQ-020 In GRANT:
- HRQ SHALL be 1.
- DACK SHALL be 1 << activeChannel.
- DACK SHALL assert in the first GRANT cycle, which is the cycle after HLDA is sampled high in REQ.
REQ-021 In GRANT, transferDone == 1 or EOP_N == 0 SHALL move the FSM to RELEASE; DACK SHALL be 0 the next cycle.
REQ-022 In GRANT, HLDA == 0 (CPU abort) SHALL move the FSM directly to IDLE, with DACK=0 and HRQ=0 the next cycle; priorityOrder SHALL be unchanged.
REQ-023 In RELEASE, HRQ and DACK SHALL be 0; the FSM SHALL return to IDLE once HLDA == 0.
REQ-024 activeChannel SHALL be stable from REQ entry until the FSM returns to IDLE.
REQ-025 A change in DREQ or maskReg during REQ, GRANT or RELEASE SHALL NOT change activeChannel; only eff[activeChannel] is consulted, in REQ.
REQ-026 With priorityType == 0, priorityOrder SHALL be held at 8'b11_10_01_00 (channel 0 highest).
REQ-027 With priorityType == 1, on the GRANT-to-RELEASE transition, the serviced channel SHALL become lowest priority. The remaining channels SHALL keep their relative order, i.e. the order SHALL rotate so that channel (activeChannel+1) mod 4 is highest.
REQ-028 If priorityType changes from 1 to 0, priorityOrder SHALL return to 8'b11_10_01_00 on the next clock.
REQ-029 When transferDone and EOP_N == 0 coincide in GRANT, the FSM SHALL go to RELEASE, and rotation SHALL occur exactly once.
REQ-030 When HLDA falls in the same cycle as transferDone, the abort rule (REQ-022) SHALL take precedence and no rotation SHALL occur.
REQ-031 DACK SHALL never have more than one bit set, and DACK != 0 SHALL imply HRQ == 1.

Reset
REQ-032 When RESET == 1 on a clock edge, the block SHALL set:
- FSM = IDLE;
- HRQ = 0;
- DACK = 4'b0000;
- grantValid = 0;
- activeChannel = 2'b00;
- priorityOrder = 8'b11_10_01_00.
REQ-033 Reset asserted in any state, including mid-GRANT, SHALL take effect on that edge and override every other input.
REQ-034 After reset releases, arbitration SHALL resume only from IDLE.

Verification
REQ-035 Fixed priority: DREQ=4'b0110, maskReg=0, HLDA raised 2 cycles after HRQ -> activeChannel=1, DACK=4'b0010 in the cycle after HLDA is sampled high, HRQ=1.
REQ-036 Masking: DREQ=4'b0011, maskReg=4'b0001 -> DACK=4'b0010; with DREQ=4'b0001 and maskReg=4'b0001 -> HRQ stays 0.
REQ-037 Rotation: priorityType=1, DREQ=4'b1111, transferDone pulsed each grant, HLDA cycled -> DACK sequence 0001, 0010, 0100, 1000, 0001; priorityOrder=8'b00_11_10_01 after the first release.
REQ-038 EOP: EOP_N=0 in GRANT for channel 2 -> RELEASE next cycle, DACK=0, HRQ=0; IDLE after HLDA falls.
REQ-039 Abort and reset: HLDA dropped in GRANT -> IDLE with priorityOrder unchanged; RESET=1 mid-GRANT -> DACK=0, HRQ=0, priorityOrder=8'b11_10_01_00 on the next edge.
REQ-040 Request withdrawal: DREQ=4'b1000 then 0 while in REQ with HLDA=0 -> IDLE, HRQ=0 the next cycle, DACK never asserted.

Source files
------------

// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA request arbiter. It picks a winner from the unmasked requests,
// runs the HRQ/HLDA handshake with the CPU, and owns the fixed or rotating priority order.
module dma_channel_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [3:0] maskReg,
    input  logic       priorityType,
    input  logic       ctrlDisable,
    input  logic       HLDA,
    input  logic       EOP_N,
    input  logic       transferDone,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic [1:0] activeChannel,
    output logic       grantValid,
    output logic [7:0] priorityOrder
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        GRANT   = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    localparam logic [7:0] FIXED_ORDER = 8'b11_10_01_00;

    state_t     state_q, state_d;
    logic [1:0] chan_q, chan_d;
    logic [7:0] order_q, order_d;
    logic [3:0] eff;
    logic [1:0] winner;
    logic       rotate;

    assign eff = DREQ & ~maskReg;

    // Scan from the lowest-priority slot upward so the highest set slot wins.
    always_comb begin
        winner = order_q[1:0];
        for (int k = 3; k >= 0; k--) begin
            if (eff[order_q[2*k +: 2]]) begin
                winner = order_q[2*k +: 2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        rotate  = 1'b0;
        case (state_q)
            IDLE: begin
                if ((eff != 4'b0000) && !ctrlDisable) begin
                    chan_d  = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (HLDA) begin
                    state_d = GRANT;
                end else if (!eff[chan_q]) begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // A CPU abort outranks completion, so an aborted transfer never rotates.
                if (!HLDA) begin
                    state_d = IDLE;
                end else if (transferDone || !EOP_N) begin
                    state_d = RELEASE;
                    rotate  = 1'b1;
                end
            end
            RELEASE: begin
                if (!HLDA) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        order_d = order_q;
        if (!priorityType) begin
            order_d = FIXED_ORDER;
        end else if (rotate) begin
            for (int k = 0; k < 4; k++) begin
                order_d[2*k +: 2] = chan_q + 2'(k + 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            chan_q  <= 2'b00;
            order_q <= FIXED_ORDER;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            order_q <= order_d;
        end
    end

    assign HRQ           = (state_q == REQ) || (state_q == GRANT);
    assign grantValid    = (state_q == GRANT);
    assign DACK          = grantValid ? (4'b0001 << chan_q) : 4'b0000;
    assign activeChannel = chan_q;
    assign priorityOrder = order_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter. Each expected grant is queued when
// its request is driven, and it is compared when DACK rises.
module tb_dma_channel_arbiter;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic       priorityType;
    logic       ctrlDisable;
    logic       HLDA;
    logic       EOP_N;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       grantValid;
    logic [7:0] priorityOrder;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] expQ[$];
    logic [3:0] prevDack = 4'b0000;
    logic       monOn = 1'b0;

    localparam logic [7:0] FIXED = 8'b11_10_01_00;

    dma_channel_arbiter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DREQ         (DREQ),
        .maskReg      (maskReg),
        .priorityType (priorityType),
        .ctrlDisable  (ctrlDisable),
        .HLDA         (HLDA),
        .EOP_N        (EOP_N),
        .transferDone (transferDone),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .activeChannel(activeChannel),
        .grantValid   (grantValid),
        .priorityOrder(priorityOrder)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard and invariant monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (monOn) begin
            checks++;
            if (grantValid !== (DACK != 4'b0000)) begin
                errors++;
                $display("[TB] FAIL grantValid: got %b expected %b", grantValid, (DACK != 4'b0000));
            end
            if (DACK !== 4'b0000) begin
                checks++;
                if (!$onehot(DACK) || HRQ !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL dackOnehotHrq: got DACK=%b HRQ=%b expected one-hot with HRQ=1", DACK, HRQ);
                end
            end
            if (DACK !== 4'b0000 && prevDack === 4'b0000) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedGrant: got DACK=%b expected no grant", DACK);
                end else begin
                    logic [3:0] exp;
                    exp = expQ.pop_front();
                    if (DACK !== exp) begin
                        errors++;
                        $display("[TB] FAIL grantValue: got DACK=%b expected %b", DACK, exp);
                    end
                end
            end
        end
        prevDack <= DACK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // endMode: 0 transferDone, 1 EOP, 2 both, 3 HLDA abort, 4 abort with transferDone
    task automatic runGrant(input string name, input logic [3:0] req, input logic [3:0] msk,
                            input logic [3:0] extraReq, input logic [3:0] expDack,
                            input logic [1:0] expChan, input int hldaDelay, input int endMode,
                            input logic [7:0] expOrder);
        int latency;
        DREQ    = req;
        maskReg = msk;
        expQ.push_back(expDack);
        tick();
        checks++;
        if (HRQ !== 1'b1 || DACK !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL %s reqPhase: got HRQ=%b DACK=%b expected HRQ=1 DACK=0000", name, HRQ, DACK);
        end
        checks++;
        if (activeChannel !== expChan) begin
            errors++;
            $display("[TB] FAIL %s reqChan: got %0d expected %0d", name, activeChannel, expChan);
        end
        DREQ = req | extraReq;
        repeat (hldaDelay) tick();
        checks++;
        if (HRQ !== 1'b1 || activeChannel !== expChan) begin
            errors++;
            $display("[TB] FAIL %s reqHold: got HRQ=%b chan=%0d expected HRQ=1 chan=%0d", name, HRQ, activeChannel, expChan);
        end
        HLDA    = 1'b1;
        latency = 0;
        for (int i = 0; i < 4 && latency == 0; i++) begin
            tick();
            if (DACK !== 4'b0000) latency = i + 1;
        end
        checks++;
        if (latency != 1) begin
            errors++;
            $display("[TB] FAIL %s grantLatency: got %0d cycles expected 1", name, latency);
        end
        checks++;
        if (HRQ !== 1'b1 || activeChannel !== expChan) begin
            errors++;
            $display("[TB] FAIL %s grantPhase: got HRQ=%b chan=%0d expected HRQ=1 chan=%0d", name, HRQ, activeChannel, expChan);
        end
        DREQ = 4'b0000;
        case (endMode)
            0: transferDone = 1'b1;
            1: EOP_N = 1'b0;
            2: begin transferDone = 1'b1; EOP_N = 1'b0; end
            3: HLDA = 1'b0;
            default: begin HLDA = 1'b0; transferDone = 1'b1; end
        endcase
        tick();
        transferDone = 1'b0;
        EOP_N        = 1'b1;
        checks++;
        if (DACK !== 4'b0000 || HRQ !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s endPhase: got HRQ=%b DACK=%b expected HRQ=0 DACK=0000", name, HRQ, DACK);
        end
        checks++;
        if (priorityOrder !== expOrder) begin
            errors++;
            $display("[TB] FAIL %s order: got %b expected %b", name, priorityOrder, expOrder);
        end
        if (endMode < 3) begin
            tick();
            checks++;
            if (HRQ !== 1'b0 || DACK !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL %s releaseHold: got HRQ=%b DACK=%b expected HRQ=0 DACK=0000", name, HRQ, DACK);
            end
            HLDA = 1'b0;
            tick();
            checks++;
            if (HRQ !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s releaseExit: got HRQ=%b expected 0", name, HRQ);
            end
        end
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        checks++;
        if (HRQ !== 1'b0 || DACK !== 4'b0000 || grantValid !== 1'b0 ||
            activeChannel !== 2'b00 || priorityOrder !== FIXED) begin
            errors++;
            $display("[TB] FAIL reset: got HRQ=%b DACK=%b gv=%b chan=%0d order=%b expected 0 0000 0 0 %b",
                     HRQ, DACK, grantValid, activeChannel, priorityOrder, FIXED);
        end
        RESET = 1'b0;
        tick();
        monOn = 1'b1;
    endtask

    task automatic test_fixed_priority();
        priorityType = 1'b0;
        runGrant("fixed", 4'b0110, 4'b0000, 4'b0001, 4'b0010, 2'd1, 2, 0, FIXED);
    endtask

    task automatic test_masking();
        runGrant("mask", 4'b0011, 4'b0001, 4'b0000, 4'b0010, 2'd1, 0, 0, FIXED);
        DREQ    = 4'b0001;
        maskReg = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (HRQ !== 1'b0) begin
                errors++;
                $display("[TB] FAIL maskedIdle: got HRQ=%b expected 0", HRQ);
            end
        end
        maskReg     = 4'b0000;
        ctrlDisable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (HRQ !== 1'b0) begin
                errors++;
                $display("[TB] FAIL disabledIdle: got HRQ=%b expected 0", HRQ);
            end
        end
        DREQ        = 4'b0000;
        ctrlDisable = 1'b0;
        tick();
    endtask

    task automatic test_rotation();
        priorityType = 1'b1;
        tick();
        runGrant("rot0", 4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 0, 0, 8'b00_11_10_01);
        runGrant("rot1", 4'b1111, 4'b0000, 4'b0000, 4'b0010, 2'd1, 0, 0, 8'b01_00_11_10);
        runGrant("rot2", 4'b1111, 4'b0000, 4'b0000, 4'b0100, 2'd2, 0, 0, 8'b10_01_00_11);
        runGrant("rot3", 4'b1111, 4'b0000, 4'b0000, 4'b1000, 2'd3, 0, 0, 8'b11_10_01_00);
        runGrant("rot4", 4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 0, 0, 8'b00_11_10_01);
    endtask

    task automatic test_coincident_end();
        runGrant("both", 4'b1111, 4'b0000, 4'b0000, 4'b0010, 2'd1, 0, 2, 8'b01_00_11_10);
    endtask

    task automatic test_abort();
        runGrant("abort", 4'b1111, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1, 3, 8'b01_00_11_10);
        runGrant("abortDone", 4'b1111, 4'b0000, 4'b0000, 4'b0100, 2'd2, 0, 4, 8'b01_00_11_10);
        priorityType = 1'b0;
        tick();
        checks++;
        if (priorityOrder !== FIXED) begin
            errors++;
            $display("[TB] FAIL fixedReturn: got %b expected %b", priorityOrder, FIXED);
        end
    endtask

    task automatic test_eop();
        runGrant("eop", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 0, 1, FIXED);
    endtask

    task automatic test_withdrawal();
        DREQ = 4'b1000;
        tick();
        checks++;
        if (HRQ !== 1'b1 || activeChannel !== 2'd3) begin
            errors++;
            $display("[TB] FAIL withdrawReq: got HRQ=%b chan=%0d expected HRQ=1 chan=3", HRQ, activeChannel);
        end
        DREQ = 4'b0000;
        tick();
        checks++;
        if (HRQ !== 1'b0 || DACK !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL withdrawIdle: got HRQ=%b DACK=%b expected HRQ=0 DACK=0000", HRQ, DACK);
        end
        tick();
    endtask

    task automatic test_back_to_back_reset();
        priorityType = 1'b1;
        runGrant("preReset", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 0, 0, 8'b00_11_10_01);
        DREQ = 4'b0100;
        expQ.push_back(4'b0100);
        tick();
        HLDA = 1'b1;
        tick();
        checks++;
        if (DACK !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL midGrant: got DACK=%b expected 0100", DACK);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (DACK !== 4'b0000 || HRQ !== 1'b0 || grantValid !== 1'b0 ||
            activeChannel !== 2'b00 || priorityOrder !== FIXED) begin
            errors++;
            $display("[TB] FAIL resetMidGrant: got DACK=%b HRQ=%b gv=%b chan=%0d order=%b expected 0000 0 0 0 %b",
                     DACK, HRQ, grantValid, activeChannel, priorityOrder, FIXED);
        end
        RESET = 1'b0;
        HLDA  = 1'b0;
        DREQ  = 4'b0000;
        tick();
        DREQ = 4'b0010;
        tick();
        checks++;
        if (HRQ !== 1'b1 || activeChannel !== 2'd1) begin
            errors++;
            $display("[TB] FAIL resume: got HRQ=%b chan=%0d expected HRQ=1 chan=1", HRQ, activeChannel);
        end
        DREQ = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        RESET        = 1'b1;
        DREQ         = 4'b0000;
        maskReg      = 4'b0000;
        priorityType = 1'b0;
        ctrlDisable  = 1'b0;
        HLDA         = 1'b0;
        EOP_N        = 1'b1;
        transferDone = 1'b0;
        test_reset();
        test_fixed_priority();
        test_masking();
        test_rotation();
        test_coincident_end();
        test_abort();
        test_eop();
        test_withdrawal();
        test_back_to_back_reset();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboardDrain: got %0d pending expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
